// File: rtl/bp_cfg_broadcast.sv
// Runtime configuration table: boot-time word writes fill image slots, and a
// select request validates one slot and streams it word by word to each masked tile.
module bp_cfg_broadcast #(
  parameter int num_cfgs_p      = 16,
  parameter int words_per_cfg_p = 8,
  parameter int data_width_p    = 64,
  parameter int num_tiles_p     = 4,
  localparam int lg_cfgs  = (num_cfgs_p > 1)      ? $clog2(num_cfgs_p)      : 1,
  localparam int lg_words = (words_per_cfg_p > 1) ? $clog2(words_per_cfg_p) : 1,
  localparam int lg_tiles = (num_tiles_p > 1)     ? $clog2(num_tiles_p)     : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    wr_v_i,
  input  logic [lg_cfgs-1:0]      wr_cfg_i,
  input  logic [lg_words-1:0]     wr_word_i,
  input  logic [data_width_p-1:0] wr_data_i,
  output logic                    wr_ready_o,
  input  logic                    sel_v_i,
  input  logic [lg_cfgs-1:0]      sel_cfg_i,
  input  logic [num_tiles_p-1:0]  sel_tile_mask_i,
  output logic                    sel_ready_o,
  output logic                    out_v_o,
  output logic [lg_tiles-1:0]     out_tile_o,
  output logic [lg_words-1:0]     out_word_o,
  output logic [data_width_p-1:0] out_data_o,
  input  logic                    out_yumi_i,
  output logic                    done_v_o,
  output logic                    done_err_o,
  output logic [lg_cfgs-1:0]      active_cfg_o
);

  localparam logic [lg_cfgs:0]    num_cfgs_lp  = (lg_cfgs+1)'(num_cfgs_p);
  localparam logic [lg_words:0]   num_words_lp = (lg_words+1)'(words_per_cfg_p);
  localparam logic [lg_words-1:0] last_word_lp = lg_words'(words_per_cfg_p - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2, ERR = 2'd3} state_e;

  state_e                      state_r, state_n_s;
  logic [lg_cfgs-1:0]          cfg_r, cfg_n_s, active_cfg_r;
  logic [num_tiles_p-1:0]      mask_r, mask_n_s, tile_oh_s, mask_left_s;
  logic [lg_tiles-1:0]         tile_r, tile_n_s;
  logic [lg_words-1:0]         word_r, word_n_s;
  logic [words_per_cfg_p-1:0]  bitmap_r [num_cfgs_p];
  logic [data_width_p-1:0]     mem_r [num_cfgs_p][words_per_cfg_p];
  logic                        wr_ready_s, wr_fire_s, sel_loaded_s, sel_err_s;

  function automatic logic [lg_tiles-1:0] lowest_bit(input logic [num_tiles_p-1:0] m);
    lowest_bit = '0;
    for (int i = num_tiles_p - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = lg_tiles'(i);
    end
  endfunction

  // The slot being streamed is write-protected so the broadcast image stays coherent.
  assign wr_ready_s = !((state_r == SEND) && (wr_cfg_i == cfg_r));
  assign wr_fire_s  = wr_v_i && wr_ready_s &&
                      ({1'b0, wr_cfg_i} < num_cfgs_lp) && ({1'b0, wr_word_i} < num_words_lp);

  // Table data storage; deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wr_fire_s) mem_r[wr_cfg_i][wr_word_i] <= wr_data_i;
  end

  // Per-word written bitmap
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_cfgs_p; i++) bitmap_r[i] <= '0;
    end else if (wr_fire_s) begin
      bitmap_r[wr_cfg_i][wr_word_i] <= 1'b1;
    end
  end

  // Select validation uses the bitmap as registered, ignoring a same-cycle write
  always_comb begin
    sel_loaded_s = 1'b0;
    if ({1'b0, sel_cfg_i} < num_cfgs_lp) sel_loaded_s = &bitmap_r[sel_cfg_i];
    else                                 sel_loaded_s = 1'b0;
    sel_err_s = (sel_cfg_i == '0) || !sel_loaded_s || (sel_tile_mask_i == '0);
  end

  // Working mask with the current tile removed
  always_comb begin
    tile_oh_s = '0;
    for (int i = 0; i < num_tiles_p; i++) tile_oh_s[i] = (tile_r == lg_tiles'(i));
    mask_left_s = mask_r & ~tile_oh_s;
  end

  // Next-state logic
  always_comb begin
    state_n_s = state_r;
    cfg_n_s   = cfg_r;
    mask_n_s  = mask_r;
    tile_n_s  = tile_r;
    word_n_s  = word_r;
    case (state_r)
      IDLE: begin
        if (sel_v_i) begin
          cfg_n_s  = sel_cfg_i;
          mask_n_s = sel_tile_mask_i;
          tile_n_s = lowest_bit(sel_tile_mask_i);
          word_n_s = '0;
          if (sel_err_s) state_n_s = ERR;
          else           state_n_s = SEND;
        end else begin
          state_n_s = IDLE;
        end
      end
      SEND: begin
        if (out_yumi_i) begin
          if (word_r == last_word_lp) begin
            mask_n_s = mask_left_s;
            word_n_s = '0;
            tile_n_s = lowest_bit(mask_left_s);
            if (mask_left_s == '0) state_n_s = DONE;
            else                   state_n_s = SEND;
          end else begin
            word_n_s = word_r + lg_words'(1);
          end
        end else begin
          state_n_s = SEND;
        end
      end
      DONE:    state_n_s = IDLE;
      ERR:     state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      cfg_r        <= '0;
      mask_r       <= '0;
      tile_r       <= '0;
      word_r       <= '0;
      active_cfg_r <= '0;
    end else begin
      state_r <= state_n_s;
      cfg_r   <= cfg_n_s;
      mask_r  <= mask_n_s;
      tile_r  <= tile_n_s;
      word_r  <= word_n_s;
      if (state_r == DONE) active_cfg_r <= cfg_r;
    end
  end

  assign wr_ready_o   = wr_ready_s;
  assign sel_ready_o  = (state_r == IDLE);
  assign out_v_o      = (state_r == SEND);
  assign out_tile_o   = tile_r;
  assign out_word_o   = word_r;
  assign out_data_o   = mem_r[cfg_r][word_r];
  assign done_v_o     = (state_r == DONE) || (state_r == ERR);
  assign done_err_o   = (state_r == ERR);
  assign active_cfg_o = active_cfg_r;

endmodule

// File: tb/tb_bp_cfg_broadcast.sv
// Bench for bp_cfg_broadcast: vector table of selects plus random selects,
// checked against a slot/bitmap model and an expected word queue.
module tb_bp_cfg_broadcast;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_v = 1'b0;
  logic [3:0]  wr_cfg = 4'd0;
  logic [2:0]  wr_word = 3'd0;
  logic [63:0] wr_data = 64'd0;
  logic        wr_ready;
  logic        sel_v = 1'b0;
  logic [3:0]  sel_cfg = 4'd0;
  logic [3:0]  sel_mask = 4'd0;
  logic        sel_ready;
  logic        out_v;
  logic [1:0]  out_tile;
  logic [2:0]  out_word;
  logic [63:0] out_data;
  logic        out_yumi = 1'b0;
  logic        done_v;
  logic        done_err;
  logic [3:0]  active_cfg;

  bp_cfg_broadcast dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .wr_v_i(wr_v), .wr_cfg_i(wr_cfg), .wr_word_i(wr_word), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready),
    .sel_v_i(sel_v), .sel_cfg_i(sel_cfg), .sel_tile_mask_i(sel_mask), .sel_ready_o(sel_ready),
    .out_v_o(out_v), .out_tile_o(out_tile), .out_word_o(out_word), .out_data_o(out_data),
    .out_yumi_i(out_yumi), .done_v_o(done_v), .done_err_o(done_err), .active_cfg_o(active_cfg)
  );

  always #5 clk = ~clk;

  typedef struct { int tile; int word; logic [63:0] data; } ent_t;
  typedef struct { logic [3:0] cfg; logic [3:0] mask; bit rnd; bit exp_err; } vec_t;

  logic [63:0] model_mem [16][8];
  bit          model_loaded [16][8];
  ent_t        q[$];
  logic [3:0]  exp_active = 4'd0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met", name);
  endtask

  function automatic bit model_err(input logic [3:0] c, input logic [3:0] m);
    bit loaded = 1'b1;
    for (int w = 0; w < 8; w++) if (!model_loaded[c][w]) loaded = 1'b0;
    return (c == 4'd0) || (m == 4'd0) || !loaded;
  endfunction

  task automatic write_word(input logic [3:0] c, input int w, input logic [63:0] d);
    wr_v = 1'b1; wr_cfg = c; wr_word = 3'(w); wr_data = d;
    @(negedge clk);
    check("wr_ready_idle", wr_ready, 1'b1);
    @(posedge clk); #1;
    wr_v = 1'b0;
    model_mem[c][w] = d;
    model_loaded[c][w] = 1'b1;
  endtask

  // Issues a select in IDLE; returns the model's verdict and fills the expected stream.
  task automatic start_select(input logic [3:0] c, input logic [3:0] m, output bit err);
    sel_v = 1'b1; sel_cfg = c; sel_mask = m;
    err = model_err(c, m);
    q.delete();
    if (!err) begin
      for (int t = 0; t < 4; t++)
        if (m[t]) for (int w = 0; w < 8; w++) q.push_back('{t, w, model_mem[c][w]});
    end
    @(negedge clk);
    check("sel_ready", sel_ready, 1'b1);
    @(posedge clk); #1;
    sel_v = 1'b0;
  endtask

  task automatic finish_select(input bit rnd, input bit exp_err, input int exp_total,
                               input logic [3:0] c);
    int n = 1;
    bit finished = 1'b0;
    while (!finished) begin
      out_yumi = out_v && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      @(negedge clk);
      if (exp_err) check("no_out_on_err", out_v, 1'b0);
      if (out_v && !exp_err) begin
        if (q.size() == 0) fail_now("extra_word");
        else begin
          check("out_tile", out_tile, q[0].tile);
          check("out_word", out_word, q[0].word);
          check("out_data", out_data, q[0].data);
          if (out_yumi) void'(q.pop_front());
        end
      end
      if (done_v) begin
        check("done_err", done_err, exp_err);
        check("words_left", q.size(), 0);
        if (exp_total != 0) check("latency", n + 1, exp_total);
        if (!exp_err) exp_active = c;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!finished && n > 400) begin
        fail_now("timeout");
        finished = 1'b1;
      end
    end
    out_yumi = 1'b0;
    check("active_cfg", active_cfg, exp_active);
  endtask

  vec_t vecs [7];

  initial begin
    bit err;
    vecs[0] = '{4'd3, 4'b0101, 1'b0, 1'b0};
    vecs[1] = '{4'd0, 4'b0001, 1'b0, 1'b1};
    vecs[2] = '{4'd5, 4'b0001, 1'b0, 1'b1};
    vecs[3] = '{4'd3, 4'b0000, 1'b0, 1'b1};
    vecs[4] = '{4'd7, 4'b1111, 1'b1, 1'b0};
    vecs[5] = '{4'd8, 4'b1000, 1'b1, 1'b0};
    vecs[6] = '{4'd4, 4'b0110, 1'b0, 1'b0};
    for (int c = 0; c < 16; c++) for (int w = 0; w < 8; w++) begin
      model_loaded[c][w] = 1'b0;
      model_mem[c][w] = 64'd0;
    end

    #12;
    check("rst_out_v", out_v, 1'b0);
    check("rst_done_v", done_v, 1'b0);
    check("rst_done_err", done_err, 1'b0);
    check("rst_active", active_cfg, 4'd0);
    check("rst_sel_ready", sel_ready, 1'b1);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 8; w++) write_word(4'd3, w, 64'h3000 + 64'(w));
    for (int w = 0; w < 8; w++) write_word(4'd4, w, {$urandom, $urandom});
    for (int w = 0; w < 7; w++) write_word(4'd5, w, {$urandom, $urandom});
    for (int w = 0; w < 7; w++) write_word(4'd6, w, {$urandom, $urandom});
    for (int w = 0; w < 8; w++) write_word(4'd7, w, {$urandom, $urandom});
    for (int w = 0; w < 8; w++) write_word(4'd8, w, {$urandom, $urandom});

    for (int i = 0; i < 7; i++) begin
      int total;
      total = vecs[i].rnd ? 0 : (vecs[i].exp_err ? 2 : $countones(vecs[i].mask) * 8 + 2);
      start_select(vecs[i].cfg, vecs[i].mask, err);
      check("vec_model_agrees", err, vecs[i].exp_err);
      finish_select(vecs[i].rnd, vecs[i].exp_err, total, vecs[i].cfg);
    end

    // Writes during a stream: own slot blocked, another slot accepted
    start_select(4'd3, 4'b0001, err);
    out_yumi = 1'b0;
    wr_v = 1'b1; wr_cfg = 4'd3; wr_word = 3'd0; wr_data = 64'hdead;
    @(negedge clk);
    check("wr_ready_busy_slot", wr_ready, 1'b0);
    check("hold_data", out_data, 64'h3000);
    @(posedge clk); #1;
    wr_cfg = 4'd4; wr_word = 3'd2; wr_data = 64'h4444_0000_0000_4444;
    @(negedge clk);
    check("wr_ready_other_slot", wr_ready, 1'b1);
    check("data_unchanged", out_data, 64'h3000);
    @(posedge clk); #1;
    wr_v = 1'b0;
    model_mem[4][2] = 64'h4444_0000_0000_4444;
    model_loaded[4][2] = 1'b1;
    finish_select(1'b0, 1'b0, 0, 4'd3);
    start_select(4'd4, 4'b0010, err);
    finish_select(1'b0, err, 10, 4'd4);

    // Final word of slot 6 written in the same cycle as its select
    wr_v = 1'b1; wr_cfg = 4'd6; wr_word = 3'd7; wr_data = 64'h6666;
    start_select(4'd6, 4'b0001, err);
    wr_v = 1'b0;
    model_mem[6][7] = 64'h6666;
    model_loaded[6][7] = 1'b1;
    finish_select(1'b0, 1'b1, 2, 4'd6);
    start_select(4'd6, 4'b1001, err);
    finish_select(1'b1, err, 0, 4'd6);
    check("slot6_now_ok", err, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [3:0] c, m;
      c = 4'($urandom_range(0, 9));
      m = 4'($urandom_range(0, 15));
      start_select(c, m, err);
      finish_select(1'b1, err, 0, c);
    end

    // Reset in the middle of a stream
    start_select(4'd3, 4'b1111, err);
    out_yumi = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    out_yumi = 1'b0;
    #1;
    check("rst_mid_out_v", out_v, 1'b0);
    check("rst_mid_done_v", done_v, 1'b0);
    for (int c = 0; c < 16; c++) for (int w = 0; w < 8; w++) model_loaded[c][w] = 1'b0;
    exp_active = 4'd0;
    q.delete();
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_active", active_cfg, 4'd0);
    check("post_rst_sel_ready", sel_ready, 1'b1);
    check("post_rst_out_v", out_v, 1'b0);
    start_select(4'd3, 4'b0001, err);
    check("post_rst_model_err", err, 1'b1);
    finish_select(1'b0, 1'b1, 2, 4'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
